// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiation datapath: default widths,
// the engine state encoding and the modular-multiplier latency.
package rsa_pkg;

    localparam int W_DEF       = 256;
    localparam int KW_DEF      = 9;
    localparam int MUL_LATENCY = W_DEF + 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_SQR      = 3'd2,
        ST_SQR_WAIT = 3'd3,
        ST_MUL      = 3'd4,
        ST_MUL_WAIT = 3'd5,
        ST_DONE     = 3'd6
    } eng_state_e;

    // Cycles one modular product costs the engine for a given operand width.
    function automatic int mul_latency(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/mod_mul_blakley.sv
// Bit-serial interleaved (Blakley) modular multiplier: p = a*b mod n.
// Walks b from MSB to LSB, one shift-add-reduce step per cycle. done pulses
// W+1 cycles after start; p holds its value until the next start.
module mod_mul_blakley
    import rsa_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] p,
    output logic         done
);

    localparam int PW = W + 2;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_n;
    logic [PW-1:0] r_p;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_done;

    logic [PW-1:0] w_dbl;
    logic [PW-1:0] w_add;
    logic [PW-1:0] w_sum;
    logic [PW-1:0] w_nx;
    logic [PW-1:0] w_sub1;
    logic [PW-1:0] w_sub2;

    // One Blakley step: 2P + (b_msb ? A : 0) is below 3N, so two
    // conditional subtractions bring it back under N.
    assign w_dbl  = r_p << 1;
    assign w_add  = r_b[W-1] ? {2'b00, r_a} : {PW{1'b0}};
    assign w_sum  = w_dbl + w_add;
    assign w_nx   = {2'b00, r_n};
    assign w_sub1 = (w_sum >= w_nx) ? (w_sum - w_nx) : w_sum;
    assign w_sub2 = (w_sub1 >= w_nx) ? (w_sub1 - w_nx) : w_sub1;

    assign p    = r_p[W-1:0];
    assign done = r_done;

    // Operand capture on start, then W reduction steps; the last step raises done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= {W{1'b0}};
            r_b    <= {W{1'b0}};
            r_n    <= {W{1'b0}};
            r_p    <= {PW{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_a   <= a;
                r_b   <= b;
                r_n   <= n;
                r_p   <= {PW{1'b0}};
                r_cnt <= CW'(W);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_p   <= w_sub2;
                r_b   <= r_b << 1;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply modular exponentiation engine:
// result = base^exp mod modulus, built on the serial Blakley multiplier.
module mod_exp_engine
    import rsa_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int KW = KW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [W-1:0]  exp,
    input  logic [W-1:0]  modulus,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  result,
    output logic          busy,
    output logic          done,
    output logic          err
);

    eng_state_e    r_state;
    eng_state_e    w_next_state;

    logic [W-1:0]  r_base;
    logic [W-1:0]  r_exp;
    logic [W-1:0]  r_mod;
    logic [KW-1:0] r_k;
    logic [KW-1:0] r_i;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_result;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_err_pend;

    logic          w_mul_start;
    logic [W-1:0]  w_mul_b;
    logic [W-1:0]  w_mul_p;
    logic          w_mul_done;
    logic          w_exp_bit;
    logic [KW-1:0] w_k_clamp;

    // Exponent lengths beyond the operand width collapse to W.
    assign w_k_clamp = (k > KW'(W)) ? KW'(W) : k;
    assign w_exp_bit = |(r_exp & (W'(1) << r_i));

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

    mod_mul_blakley #(
        .W(W)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (w_mul_start),
        .a     (r_acc),
        .b     (w_mul_b),
        .n     (r_mod),
        .p     (w_mul_p),
        .done  (w_mul_done)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and multiplier issue control.
    always_comb begin
        w_next_state = r_state;
        w_mul_start  = 1'b0;
        w_mul_b      = r_acc;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if ((r_mod <= W'(1)) || (r_base >= r_mod) || (r_k == KW'(0))) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SQR;
                end
            end
            ST_SQR: begin
                w_mul_start  = 1'b1;
                w_mul_b      = r_acc;
                w_next_state = ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
                if (!w_mul_done) begin
                    w_next_state = ST_SQR_WAIT;
                end else if (w_exp_bit) begin
                    w_next_state = ST_MUL;
                end else if (r_i == KW'(0)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SQR;
                end
            end
            ST_MUL: begin
                w_mul_start  = 1'b1;
                w_mul_b      = r_base;
                w_next_state = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (!w_mul_done) begin
                    w_next_state = ST_MUL_WAIT;
                end else if (r_i == KW'(0)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SQR;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture, accumulator/bit-index update and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base     <= {W{1'b0}};
            r_exp      <= {W{1'b0}};
            r_mod      <= {W{1'b0}};
            r_k        <= {KW{1'b0}};
            r_i        <= {KW{1'b0}};
            r_acc      <= {W{1'b0}};
            r_result   <= {W{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base     <= base;
                        r_exp      <= exp;
                        r_mod      <= modulus;
                        r_k        <= w_k_clamp;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_err_pend <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (r_mod <= W'(1)) begin
                        r_acc <= {W{1'b0}};
                    end else if (r_base >= r_mod) begin
                        r_acc      <= {W{1'b0}};
                        r_err_pend <= 1'b1;
                    end else begin
                        // Both k == 0 and the normal path start from R = 1.
                        r_acc <= W'(1);
                        r_i   <= r_k - KW'(1);
                    end
                end
                ST_SQR_WAIT, ST_MUL_WAIT: begin
                    if (w_mul_done) begin
                        r_acc <= w_mul_p;
                    end
                    if (w_next_state == ST_SQR) begin
                        r_i <= r_i - KW'(1);
                    end
                end
                ST_DONE: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_err    <= r_err_pend;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed and reference-model bench for mod_exp_engine at W=16 and W=256.
module tb_mod_exp_engine;

    localparam int WS = 16;
    localparam int WL = 256;
    localparam int KW = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_start;
    logic [WS-1:0] a_base, a_exp, a_mod, a_result;
    logic [KW-1:0] a_k;
    logic          a_busy, a_done, a_err;

    logic          b_start;
    logic [WL-1:0] b_base, b_exp, b_mod, b_result;
    logic [KW-1:0] b_k;
    logic          b_busy, b_done, b_err;

    int total = 0;
    int bad   = 0;

    mod_exp_engine #(.W(WS), .KW(KW)) dut16 (
        .clk(clk), .reset(reset), .start(a_start), .base(a_base), .exp(a_exp),
        .modulus(a_mod), .k(a_k), .result(a_result), .busy(a_busy), .done(a_done), .err(a_err)
    );

    mod_exp_engine #(.W(WL), .KW(KW)) dut256 (
        .clk(clk), .reset(reset), .start(b_start), .base(b_base), .exp(b_exp),
        .modulus(b_mod), .k(b_k), .result(b_result), .busy(b_busy), .done(b_done), .err(b_err)
    );

    typedef struct {
        logic [WS-1:0] base;
        logic [WS-1:0] ex;
        logic [WS-1:0] md;
        logic [KW-1:0] k;
        logic [WS-1:0] res;
        logic          err;
        int            lat;
        int            inj_cycle;
    } vec_t;

    task automatic chk(input string name, input logic [WL-1:0] act, input logic [WL-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Called at posedge+1: start in this cycle, run to done. inj_cycle > 0
    // pulses a second start with other operands while the engine is busy.
    task automatic run16(input vec_t v, input string tag);
        int lat;
        int low_busy;
        logic got;
        a_base  = v.base;
        a_exp   = v.ex;
        a_mod   = v.md;
        a_k     = v.k;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_base  = ~v.base;
        a_exp   = ~v.ex;
        a_mod   = 16'd3;
        a_k     = 9'd2;
        chk({tag, "_busy_after_start"}, 256'(a_busy), 256'(1'b1));
        chk({tag, "_err_cleared"}, 256'(a_err), 256'(1'b0));
        lat = 0;
        low_busy = 0;
        got = 1'b0;
        while (!got && lat < v.lat + 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat == v.inj_cycle) begin
                a_start = 1'b1;
                a_base  = 16'd5;
                a_exp   = 16'd7;
                a_mod   = 16'd11;
                a_k     = 9'd3;
            end else begin
                a_start = 1'b0;
            end
            if (a_done) begin
                got = 1'b1;
            end else if (!a_busy) begin
                low_busy++;
            end
        end
        chk({tag, "_done_seen"}, 256'(got), 256'(1'b1));
        chk({tag, "_busy_gaps"}, 256'(low_busy), 256'(0));
        chk({tag, "_latency"}, 256'(lat), 256'(v.lat));
        chk({tag, "_result"}, 256'(a_result), 256'(v.res));
        chk({tag, "_err"}, 256'(a_err), 256'(v.err));
        chk({tag, "_busy_at_done"}, 256'(a_busy), 256'(1'b0));
    endtask

    function automatic logic [WL-1:0] mulmod(input logic [WL-1:0] x, input logic [WL-1:0] y,
                                             input logic [WL-1:0] n);
        logic [2*WL-1:0] pr;
        logic [2*WL-1:0] q;
        pr = {{WL{1'b0}}, x} * {{WL{1'b0}}, y};
        q  = pr % {{WL{1'b0}}, n};
        return q[WL-1:0];
    endfunction

    function automatic logic [WL-1:0] modexp(input logic [WL-1:0] bs, input logic [WL-1:0] e,
                                             input logic [WL-1:0] n, input int kk);
        logic [WL-1:0] r;
        r = 256'd1;
        for (int i = kk - 1; i >= 0; i--) begin
            r = mulmod(r, r, n);
            if (e[i]) r = mulmod(r, bs, n);
        end
        return r;
    endfunction

    // One W=256 run against the reference model, checking result and latency.
    task automatic run256(input int idx);
        logic [WL-1:0] n, bs, e, raw, want;
        int kk, h, lat, want_lat;
        logic got;
        for (int j = 0; j < 8; j++) n[j*32 +: 32] = $urandom();
        n[WL-1] = 1'b1;
        for (int j = 0; j < 8; j++) raw[j*32 +: 32] = $urandom();
        bs = raw % n;
        kk = $urandom_range(1, 6);
        e = '0;
        e[5:0] = 6'($urandom_range(0, 63));
        e = e & ((256'd1 << kk) - 256'd1);
        e[kk-1] = 1'b1;
        h = 0;
        for (int j = 0; j < kk; j++) h += int'(e[j]);
        want = modexp(bs, e, n, kk);
        want_lat = 2 + (kk + h) * (WL + 2);
        b_base  = bs;
        b_exp   = e;
        b_mod   = n;
        b_k     = KW'(kk);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < want_lat + 100) begin
            @(posedge clk); #1;
            lat++;
            if (b_done) got = 1'b1;
        end
        chk($sformatf("w256_%0d_done_seen", idx), 256'(got), 256'(1'b1));
        chk($sformatf("w256_%0d_latency", idx), 256'(lat), 256'(want_lat));
        chk($sformatf("w256_%0d_result", idx), b_result, want);
        chk($sformatf("w256_%0d_err", idx), 256'(b_err), 256'(1'b0));
    endtask

    vec_t vecs[9];

    initial begin
        int lat;
        int rst_done;
        vec_t v;

        vecs[0] = '{16'd4,  16'd13,    16'd497,  9'd4,   16'd445, 1'b0, 128, 0};
        vecs[1] = '{16'd2,  16'd10,    16'd1000, 9'd4,   16'd24,  1'b0, 110, 0};
        vecs[2] = '{16'd7,  16'd0,     16'd13,   9'd0,   16'd1,   1'b0, 2,   0};
        vecs[3] = '{16'd20, 16'd13,    16'd13,   9'd4,   16'd0,   1'b1, 2,   0};
        vecs[4] = '{16'd20, 16'd13,    16'd1,    9'd4,   16'd0,   1'b0, 2,   0};
        vecs[5] = '{16'd20, 16'd13,    16'd0,    9'd4,   16'd0,   1'b0, 2,   0};
        vecs[6] = '{16'd4,  16'd13,    16'd497,  9'd4,   16'd445, 1'b0, 128, 50};
        vecs[7] = '{16'd3,  16'd1,     16'd7,    9'd300, 16'd3,   1'b0, 308, 0};
        vecs[8] = '{16'd4,  16'hFF0D,  16'd497,  9'd4,   16'd445, 1'b0, 128, 0};

        reset   = 1'b1;
        a_start = 1'b0; a_base = '0; a_exp = '0; a_mod = '0; a_k = '0;
        b_start = 1'b0; b_base = '0; b_exp = '0; b_mod = '0; b_k = '0;
        #2;
        chk("rst_result", 256'(a_result), 256'(0));
        chk("rst_busy", 256'(a_busy), 256'(0));
        chk("rst_done", 256'(a_done), 256'(0));
        chk("rst_err", 256'(a_err), 256'(0));
        chk("rst_result256", b_result, 256'(0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Back-to-back vectors: each start lands in the cycle after the previous done.
        for (int i = 0; i < 9; i++) begin
            run16(vecs[i], $sformatf("v%0d", i));
        end

        // done is a single-cycle pulse and result holds afterwards.
        @(posedge clk); #1;
        chk("done_one_cycle", 256'(a_done), 256'(0));
        chk("result_held", 256'(a_result), 256'(16'd445));

        // Reset during the 4^13 run aborts asynchronously without a done pulse.
        a_base = 16'd4; a_exp = 16'd13; a_mod = 16'd497; a_k = 9'd4;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        lat = 0;
        rst_done = 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (a_done) rst_done++;
        end
        chk("pre_reset_busy", 256'(a_busy), 256'(1'b1));
        reset = 1'b1;
        #1;
        chk("async_rst_busy", 256'(a_busy), 256'(0));
        chk("async_rst_done", 256'(a_done), 256'(0));
        chk("async_rst_result", 256'(a_result), 256'(0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (a_done) rst_done++;
        end
        reset = 1'b0;
        for (int c = 0; c < 140; c++) begin
            @(posedge clk); #1;
            if (a_done) rst_done++;
        end
        chk("no_done_after_abort", 256'(rst_done), 256'(0));
        v = vecs[1];
        run16(v, "post_reset");

        for (int i = 0; i < 20; i++) begin
            run256(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_exp_engine.md
Name: mod_exp_engine

Overview:
- Computes result = base^exp mod modulus by left-to-right binary square-and-multiply.
- Sits directly downstream of the GPIO byte-loader top, which supplies base, exponent, modulus and exponent bit-length k.
- Returns the result and a done indication for byte-wise readout.
- All modular products use a bit-serial interleaved (Blakley) shift-add-subtract multiplier, so no wide multiplier is needed.

Parameters:
- W, 256, operand and result width in bits.
- KW, 9, width of the exponent bit-length input; must satisfy 2^KW > W.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; accepted only in IDLE
- base  input  W  operand; precondition base < modulus
- exp  input  W  exponent; only bits [k-1:0] are used
- modulus  input  W  modulus N
- k  input  KW  exponent bit-length (index of top set bit + 1); values above W are treated as W
- result  output  W  base^exp mod N; held until the next accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when result is valid
- err  output  1  set with done when base >= modulus; cleared by the next accepted start

Behaviour:
- Reset (asynchronous): state IDLE; result, busy, done, err all 0; internal registers 0.
- On start in IDLE, base, exp, modulus and k are captured in the same edge; later input changes have no effect.
- start while busy is ignored.
- States: IDLE -> CHECK -> (SQR -> SQR_WAIT -> [MUL -> MUL_WAIT]) repeated per bit -> DONE -> IDLE.
- CHECK (1 cycle):
  - modulus <= 1: result = 0, go to DONE.
  - base >= modulus: err = 1, result = 0, go to DONE.
  - k == 0: result = 1, go to DONE.
  - Otherwise accumulator R = 1, bit index i = min(k,W) - 1, go to SQR.
- SQR issues mul(R,R); SQR_WAIT holds until the sub-module finishes and loads R.
  - If exp[i] = 1, go to MUL, which issues mul(R,base_captured); MUL_WAIT loads R.
  - Then, if i == 0, go to DONE; else decrement i and go to SQR.
- DONE (1 cycle): result = R, done = 1, busy = 0; next cycle IDLE.
- Each mul call costs exactly W+2 cycles from issue state to the wait-state exit.
- Latency from start edge to done pulse = 2 + (k + h)*(W+2), where h = popcount(exp[k-1:0]). The fast-exit paths take exactly 2 cycles.
- The first square, R=1 squared, is not skipped; this keeps the latency formula exact.
- Arithmetic:
  - All intermediates are W+2 bits wide.
  - Each Blakley step computes P = 2P + (b_j ? A : 0), then subtracts N at most twice so that P < N.
  - Operands are always < N, so two subtracts always suffice.
- Reset mid-operation aborts immediately. No done pulse is produced, and result returns to 0.

Decomposition:
- Shared package (rsa_pkg):
  - W and KW defaults
  - engine state enumeration
  - mul_latency constant = W+2
- One sub-module: mod_mul_blakley (ports clk, reset, start, a, b, n, p, done).
  - Bit-serial over b from MSB to LSB.
  - Fixed latency W+1 cycles from start to a one-cycle done pulse.
  - p is held after done.

Test Plan:
- W=16, base=4, exp=13, modulus=497, k=4 -> result=445, err=0; done exactly 2+7*18=128 cycles after start; busy high throughout.
- W=16, base=2, exp=10, modulus=1000, k=4 -> result=24 after 2+6*18=110 cycles. Then base=7, exp=0, k=0, modulus=13 -> result=1 after 2 cycles.
- W=16, base=20, modulus=13 -> done after 2 cycles with err=1 and result=0. Then modulus=1 -> result=0 and err=0. Then modulus=0 -> result=0.
- W=16, pulse start again at cycle 50 of the 4^13 run with different operands -> ignored; result still 445 at cycle 128. A start in the cycle after done is accepted.
- W=16, assert reset at cycle 60 of the 4^13 run -> busy, done, result go to 0 asynchronously with no done pulse. After release, a new start completes correctly.
- W=256, random base < N, random exp, k from the top set bit; 20 runs compared against a reference model -> results match and latency equals 2+(k+h)*258.
